// File: rtl/if_pkg.sv
// Shared types and constants for the rv32i instruction-fetch stage.
// Misaligned-redirect trapping in if_stage is enabled by IF_MISALIGN_TRAP_EN.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } if_state_e;

    localparam int          ILEN                 = 32;
    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries toward decode.
// Power-of-two depth; clear empties it in one cycle and wins over push/pop.
module if_fifo
    import if_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests so an empty pop or a full push can never corrupt state
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/if_stage.sv
// rv32i fetch front end: owns the fetch PC, issues credit-limited word requests
// and buffers responses toward decode. Define IF_MISALIGN_TRAP_EN to trap misaligned redirects.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if_state_e     state_r;
    if_state_e     state_nxt_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [31:0]   redirect_tgt_s;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] outstanding_nxt_s;
    logic [CW-1:0] discard_r;
    logic [CW-1:0] discard_nxt_s;
    logic [CW-1:0] redirect_left_s;
    logic [CW-1:0] fifo_count_s;
    logic [CW:0]   credit_used_s;
    logic          req_valid_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          misaligned_s;
    logic [63:0]   head_s;

    if_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push_s),
        .push_data ({rsp_pc_r, imem_rsp_data}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (fifo_count_s)
    );

    // Issue/accept qualification; credits cover both in-flight and buffered words
    always_comb begin
        redirect_tgt_s  = align_word(redirect_pc);
`ifdef IF_MISALIGN_TRAP_EN
        misaligned_s    = (redirect_pc[1:0] != 2'b00);
`else
        misaligned_s    = 1'b0;
`endif
        credit_used_s   = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        req_valid_s     = reset && (state_r == FETCH) && !redirect_valid &&
                          (credit_used_s < (CW + 1)'(FIFO_DEPTH));
        issue_s         = req_valid_s && imem_req_ready;
        push_s          = imem_rsp_valid && (state_r == FETCH) && !redirect_valid;
        pop_s           = instr_valid && instr_ready && !redirect_valid;
        redirect_left_s = outstanding_r - CW'(imem_rsp_valid);
    end

    // Next-state and in-flight bookkeeping; a redirect overrides everything else
    always_comb begin
        state_nxt_s       = state_r;
        outstanding_nxt_s = outstanding_r;
        discard_nxt_s     = discard_r;
        if (redirect_valid) begin
            outstanding_nxt_s = redirect_left_s;
            discard_nxt_s     = redirect_left_s;
            if (misaligned_s) begin
                state_nxt_s = HALT;
            end else if (redirect_left_s != {CW{1'b0}}) begin
                state_nxt_s = FLUSH;
            end else begin
                state_nxt_s = FETCH;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (issue_s && !imem_rsp_valid) begin
                        outstanding_nxt_s = outstanding_r + CW'(1);
                    end else if (!issue_s && imem_rsp_valid) begin
                        outstanding_nxt_s = outstanding_r - CW'(1);
                    end else begin
                        outstanding_nxt_s = outstanding_r;
                    end
                end
                FLUSH: begin
                    if (imem_rsp_valid && (discard_r != {CW{1'b0}})) begin
                        outstanding_nxt_s = outstanding_r - CW'(1);
                        discard_nxt_s     = discard_r - CW'(1);
                        state_nxt_s       = (discard_r == CW'(1)) ? FETCH : FLUSH;
                    end else begin
                        state_nxt_s = FLUSH;
                    end
                end
`ifdef IF_MISALIGN_TRAP_EN
                HALT: begin
                    // Stale responses drain here while waiting for an aligned redirect
                    if (imem_rsp_valid && (discard_r != {CW{1'b0}})) begin
                        outstanding_nxt_s = outstanding_r - CW'(1);
                        discard_nxt_s     = discard_r - CW'(1);
                    end else begin
                        discard_nxt_s = discard_r;
                    end
                end
`endif
                default: begin
                    state_nxt_s       = FETCH;
                    outstanding_nxt_s = {CW{1'b0}};
                    discard_nxt_s     = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, counters and the fetch/response PC registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= FETCH;
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            fetch_pc_r    <= RESET_VECTOR;
            rsp_pc_r      <= RESET_VECTOR;
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_tgt_s;
                rsp_pc_r   <= redirect_tgt_s;
            end else begin
                if (issue_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + PC_STEP;
                end
            end
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic misaligned_r;

    // Sticky trap flag, cleared only by the next aligned redirect
    always_ff @(posedge clk) begin
        if (!reset) begin
            misaligned_r <= 1'b0;
        end else if (redirect_valid) begin
            misaligned_r <= misaligned_s;
        end else begin
            misaligned_r <= misaligned_r;
        end
    end

    assign fetch_misaligned = misaligned_r;
`else
    assign fetch_misaligned = 1'b0;
`endif

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;
    assign instr_valid    = (fifo_count_s != {CW{1'b0}});
    assign instr          = head_s[31:0];
    assign instr_pc       = head_s[63:32];

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a memory model answers fetches in order
// and decode must see exactly the words fetched since the last redirect, in order.
module tb_if_stage;

    localparam logic [31:0] RV         = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misaligned;

    if_stage #(.RESET_VECTOR(RV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pops = 0;
    int epoch = 0;
    int rdy_prob = 100, rsp_prob = 100, irdy_prob = 100, redir_prob = 0;
    logic        redir_pend = 1'b0;
    logic [31:0] redir_tgt = 32'h0;

    // Reference state: memory in-flight queue and expected decode stream
    logic [31:0] mem_q[$];
    int          mem_ep[$];
    logic [31:0] sb_pc[$];
    logic [31:0] sb_data[$];
    logic [31:0] exp_addr = RV;
    logic        exp_mis = 1'b0;
    logic        prev_redir = 1'b0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        int r;
        r = $urandom_range(7);
        t = $urandom & 32'h0000_FFFC;
        if (r == 0) t = 32'hFFFF_FFF8;
        if (r == 1) t[1:0] = 2'b10;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        imem_req_ready = ($urandom_range(99) < rdy_prob);
        instr_ready    = ($urandom_range(99) < irdy_prob);
        if (reset && (mem_q.size() != 0) && ($urandom_range(99) < rsp_prob)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mem_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        redirect_valid = redir_pend;
        redirect_pc    = redir_tgt;
        redir_pend     = 1'b0;
        if (!redirect_valid && ($urandom_range(99) < redir_prob)) begin
            redirect_valid = 1'b1;
            redirect_pc    = rand_tgt();
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redir_pend = 1'b1;
        redir_tgt  = pc;
        step();
        step();
    endtask

    task automatic wait_instr(input logic [31:0] pc, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
            else step();
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: timeout got no instr expected pc %h", name, pc);
        end else begin
            chk(name, instr_pc, pc);
        end
    endtask

    // Monitor: memory bookkeeping, request-address and credit checks, scoreboard pops
    always @(negedge clk) begin
        int cur_inflight;
        int occ;
        if (!reset) begin
            mem_q.delete(); mem_ep.delete(); sb_pc.delete(); sb_data.delete();
            exp_addr = RV; exp_mis = 1'b0; prev_redir = 1'b0;
        end else begin
            cur_inflight = 0;
            foreach (mem_ep[i]) if (mem_ep[i] == epoch) cur_inflight++;
            occ = mem_q.size() + sb_pc.size() - cur_inflight;
            chk("misaligned_flag", {31'd0, fetch_misaligned}, {31'd0, exp_mis});
            if (prev_redir) chk("empty_after_redirect", {31'd0, instr_valid}, 32'd0);
            if (exp_mis) chk("halt_no_request", {31'd0, imem_req_valid}, 32'd0);
            if (imem_rsp_valid && mem_q.size() != 0) begin
                void'(mem_q.pop_front());
                void'(mem_ep.pop_front());
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                if (sb_pc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
                end else begin
                    chk("instr_pc", instr_pc, sb_pc.pop_front());
                    chk("instr_data", instr, sb_data.pop_front());
                    pops++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_addr);
                chk("credit_limit", {31'd0, (occ < FIFO_DEPTH)}, 32'd1);
                mem_q.push_back(imem_req_addr);
                mem_ep.push_back(epoch);
                sb_pc.push_back(exp_addr);
                sb_data.push_back(memfn(exp_addr));
                exp_addr = exp_addr + 32'd4;
            end
            if (redirect_valid) begin
                epoch++;
                sb_pc.delete();
                sb_data.delete();
                exp_addr = redirect_pc & ~32'h3;
`ifdef IF_MISALIGN_TRAP_EN
                exp_mis = (redirect_pc[1:0] != 2'b00);
`else
                exp_mis = 1'b0;
`endif
            end
            prev_redir = redirect_valid;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RV);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);

        // Latency from reset release to first instruction
        @(posedge clk);
        #1;
        reset = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, RV);
        chk("first_cyc_a_valid", {31'd0, instr_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("first_cyc_b_valid", {31'd0, instr_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("first_cyc_c_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_cyc_c_pc", instr_pc, RV);
        repeat (20) step();

        // Decode stall: issue stops once buffer and in-flight credits are used
        irdy_prob = 0;
        repeat (10) step();
        @(negedge clk);
        chk("stall_req_stopped", {31'd0, imem_req_valid}, 32'd0);
        chk("stall_instr_held", {31'd0, instr_valid}, 32'd1);
        irdy_prob = 100;
        rsp_prob = 0;
        repeat (6) step();
        @(negedge clk);
        chk("held_rsp_no_credit", {31'd0, imem_req_valid}, 32'd0);

        // Redirect with responses still in flight
        redirect_to(32'h0000_0100);
        rsp_prob = 100;
        wait_instr(32'h0000_0100, "redirect_0x100");
        repeat (10) step();

        // PC wrap
        redirect_to(32'hFFFF_FFFC);
        wait_instr(32'hFFFF_FFFC, "wrap_first");
        repeat (10) step();

        // Misaligned redirect
        redirect_to(32'h0000_0102);
`ifdef IF_MISALIGN_TRAP_EN
        repeat (5) step();
        @(negedge clk);
        chk("trap_flag", {31'd0, fetch_misaligned}, 32'd1);
        chk("trap_no_req", {31'd0, imem_req_valid}, 32'd0);
        redirect_to(32'h0000_0200);
        wait_instr(32'h0000_0200, "trap_resume");
`else
        wait_instr(32'h0000_0100, "misaligned_forced");
`endif

        // Random traffic with a mid-run reset
        rdy_prob = 70; rsp_prob = 60; irdy_prob = 70; redir_prob = 3;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500) begin
                reset = 1'b0;
                repeat (2) step();
                @(negedge clk);
                chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
                step();
                reset = 1'b1;
            end
        end

        // Drain: everything fetched must reach decode
        rdy_prob = 100; rsp_prob = 100; irdy_prob = 100; redir_prob = 0;
        redirect_to(32'h0000_0400);
        repeat (20) step();
        irdy_prob = 0;
        rdy_prob = 0;
        for (int i = 0; i < 100 && mem_q.size() != 0; i++) step();
        irdy_prob = 100;
        for (int i = 0; i < 100 && sb_pc.size() != 0; i++) step();
        @(negedge clk);
        chk("drain_empty", sb_pc.size(), 32'd0);
        chk("liveness", {31'd0, (pops > 200)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
